// File: rtl/dbi_dma_pkg.sv
// dbi_dma_pkg: shared types and constants for the DBI DMA burst writer.
// FSM encoding, AXI response codes and beat geometry.
package dbi_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } dma_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int PXL_PER_BEAT = 32;
    localparam int BEAT_BYTES   = 32;

    // Counter width helper that never returns zero.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/dbi_dma_beat_fifo.sv
// dbi_dma_beat_fifo: synchronous FIFO with fall-through head and level output.
// Push on full and pop on empty are ignored.
module dbi_dma_beat_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/dbi_dma_burst_writer.sv
// dbi_dma_burst_writer: packs 8-bit pixels into 256-bit beats and writes them as AXI4 bursts.
// Optional DBI_DMA_BRESP_CHK_EN: a bresp error latches err_o and halts further bursts until rst.
module dbi_dma_burst_writer
    import dbi_dma_pkg::*;
#(
    parameter int                   DMA_DATA_W        = 256,
    parameter int                   ADDR_W            = 32,
    parameter int                   MST_ID_W          = 5,
    parameter logic [MST_ID_W-1:0]  DMA_ID            = 5'h01,
    parameter int                   PXL_W             = 8,
    parameter int                   BURST_LEN         = 16,
    parameter int                   FRAME_PXL         = 76800,
    parameter logic [ADDR_W-1:0]    IP_DATA_BASE_ADDR = 32'h2000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PXL_W-1:0]        pxl_dat_i,
    input  logic                    pxl_vld_i,
    input  logic                    pxl_last_i,
    output logic                    pxl_rdy_o,
    output logic [MST_ID_W-1:0]     m_awid_o,
    output logic [ADDR_W-1:0]       m_awaddr_o,
    output logic [7:0]              m_awlen_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DMA_DATA_W-1:0]   m_wdata_o,
    output logic                    m_wlast_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [MST_ID_W-1:0]     m_bid_i,
    input  logic [1:0]              m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    output logic                    frame_done_o,
    output logic                    err_o
);

    localparam int FIFO_DEPTH = 2 * BURST_LEN;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W      = $clog2(PXL_PER_BEAT);
    localparam int NBURST     = FRAME_PXL / (PXL_PER_BEAT * BURST_LEN);
    localparam int BCW        = clog2_min1(NBURST);
    localparam int BLW        = clog2_min1(BURST_LEN);
    localparam int ADDR_STEP  = BURST_LEN * BEAT_BYTES;

    // Packer
    logic [IDX_W-1:0]      r_idx;
    logic [DMA_DATA_W-1:0] r_beat;
    logic [DMA_DATA_W-1:0] w_beat_nxt;
    logic                  w_pxl_hs;
    logic                  w_push;
    logic                  w_idx_end;
    logic                  w_close_early;

    // FIFO
    logic [DMA_DATA_W-1:0] w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [LVL_W-1:0]      w_fifo_level;
    logic                  w_pop;

    // Burst engine
    dma_state_e            r_state;
    dma_state_e            w_state_nxt;
    logic [BLW-1:0]        r_wbeat;
    logic [BCW-1:0]        r_burst;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_err;
    logic                  w_halt;
    logic                  w_awvalid;
    logic                  w_wvalid;
    logic                  w_bready;
    logic                  w_last_beat;
    logic                  w_last_burst;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_bresp_bad;
    logic                  w_unused;

    assign w_pxl_hs      = pxl_vld_i && pxl_rdy_o;
    assign w_idx_end     = (r_idx == IDX_W'(PXL_PER_BEAT-1));
    assign w_push        = w_pxl_hs && (w_idx_end || pxl_last_i);
    assign w_close_early = w_pxl_hs && pxl_last_i && !w_idx_end;
    assign pxl_rdy_o     = !w_fifo_full;

    // Merge the incoming pixel into its byte lane; pixel 0 lands in the LSBs.
    always_comb begin
        w_beat_nxt = r_beat;
        w_beat_nxt[int'(r_idx)*PXL_W +: PXL_W] = pxl_dat_i;
    end

    // Lane index and partial beat; cleared on every push so short beats are zero-padded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_beat <= '0;
        end else if (w_pxl_hs) begin
            if (w_push) begin
                r_idx  <= '0;
                r_beat <= '0;
            end else begin
                r_idx  <= r_idx + 1'b1;
                r_beat <= w_beat_nxt;
            end
        end
    end

    dbi_dma_beat_fifo #(
        .WIDTH (DMA_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_beat_nxt),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    assign w_last_beat  = (r_wbeat == BLW'(BURST_LEN-1));
    assign w_last_burst = (r_burst == BCW'(NBURST-1));
    assign w_w_hs       = w_wvalid && m_wready_i;
    assign w_b_hs       = w_bready && m_bvalid_i;
    assign w_bresp_bad  = (m_bresp_i != RESP_OKAY);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and channel strobes; a burst starts only once it is fully buffered.
    always_comb begin
        w_state_nxt = r_state;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_halt && (w_fifo_level >= LVL_W'(BURST_LEN))) begin
                    w_state_nxt = ST_AW;
                end
            end
            ST_AW: begin
                w_awvalid = 1'b1;
                if (m_awready_i) begin
                    w_state_nxt = ST_W;
                end
            end
            ST_W: begin
                w_wvalid = 1'b1;
                w_pop    = m_wready_i;
                if (m_wready_i && w_last_beat) begin
                    w_state_nxt = ST_B;
                end
            end
            ST_B: begin
                w_bready = 1'b1;
                if (m_bvalid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Beat-in-burst, burst-in-frame and address counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbeat <= '0;
            r_burst <= '0;
            r_addr  <= IP_DATA_BASE_ADDR;
        end else begin
            if (w_w_hs) begin
                r_wbeat <= w_last_beat ? '0 : r_wbeat + 1'b1;
            end
            if (w_b_hs) begin
                if (w_last_burst) begin
                    r_burst <= '0;
                    r_addr  <= IP_DATA_BASE_ADDR;
                end else begin
                    r_burst <= r_burst + 1'b1;
                    r_addr  <= r_addr + ADDR_W'(ADDR_STEP);
                end
            end
        end
    end

`ifdef DBI_DMA_BRESP_CHK_EN
    logic r_halt;

    // Latch a failed write response; it blocks further bursts until rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt <= 1'b0;
        end else if (w_b_hs && w_bresp_bad) begin
            r_halt <= 1'b1;
        end
    end

    assign w_halt = r_halt;

    // Sticky error: short beat from an early pxl_last_i, or a failed write response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_close_early || (w_b_hs && w_bresp_bad)) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_halt = 1'b0;

    // Sticky error: short beat from an early pxl_last_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_close_early) begin
            r_err <= 1'b1;
        end
    end
`endif

    assign w_unused = ^{m_bid_i, w_bresp_bad, w_fifo_empty};

    assign m_awid_o     = DMA_ID;
    assign m_awaddr_o   = r_addr;
    assign m_awlen_o    = 8'(BURST_LEN-1);
    assign m_awvalid_o  = w_awvalid;
    assign m_wvalid_o   = w_wvalid;
    assign m_wdata_o    = w_wvalid ? w_fifo_head : '0;
    assign m_wlast_o    = w_wvalid && w_last_beat;
    assign m_bready_o   = w_bready;
    assign frame_done_o = w_b_hs && w_last_burst;
    assign err_o        = r_err;

endmodule

// File: tb/tb_dbi_dma_burst_writer.sv
// tb_dbi_dma_burst_writer: randomized bench with a queue-based pixel/beat model.
// Uses a 6-burst frame so every scenario fits in a short run.
module tb_dbi_dma_burst_writer;

    localparam int          FRAME = 3072;
    localparam int          BL    = 16;
    localparam int          NB    = FRAME / (32 * BL);
    localparam logic [31:0] BASE  = 32'h2000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   pxl_dat_i;
    logic         pxl_vld_i;
    logic         pxl_last_i;
    logic         pxl_rdy_o;
    logic [4:0]   m_awid_o;
    logic [31:0]  m_awaddr_o;
    logic [7:0]   m_awlen_o;
    logic         m_awvalid_o;
    logic         m_awready_i;
    logic [255:0] m_wdata_o;
    logic         m_wlast_o;
    logic         m_wvalid_o;
    logic         m_wready_i;
    logic [4:0]   m_bid_i;
    logic [1:0]   m_bresp_i;
    logic         m_bvalid_i;
    logic         m_bready_o;
    logic         frame_done_o;
    logic         err_o;

    always #5 clk = ~clk;

    dbi_dma_burst_writer #(
        .FRAME_PXL (FRAME)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pxl_dat_i    (pxl_dat_i),
        .pxl_vld_i    (pxl_vld_i),
        .pxl_last_i   (pxl_last_i),
        .pxl_rdy_o    (pxl_rdy_o),
        .m_awid_o     (m_awid_o),
        .m_awaddr_o   (m_awaddr_o),
        .m_awlen_o    (m_awlen_o),
        .m_awvalid_o  (m_awvalid_o),
        .m_awready_i  (m_awready_i),
        .m_wdata_o    (m_wdata_o),
        .m_wlast_o    (m_wlast_o),
        .m_wvalid_o   (m_wvalid_o),
        .m_wready_i   (m_wready_i),
        .m_bid_i      (m_bid_i),
        .m_bresp_i    (m_bresp_i),
        .m_bvalid_i   (m_bvalid_i),
        .m_bready_o   (m_bready_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [255:0] q[$];
    logic [7:0]   cur[$];
    logic [255:0] first_beat;
    int p, pix_total, last_at;
    int aw_cnt, b_cnt, w_tot, wbeat, pend_b, fd_cnt;
    int vld_pct, aw_pct, w_pct, b_pct;
    int err_burst = -1;
    int rst_wbeat = -1;
    int pad_beat  = -1;
    bit in_w, halted, rand_dat, first_chk, did_rst;

    task automatic model_clear();
        q.delete();
        cur.delete();
        p = 0;
        aw_cnt = 0;
        b_cnt = 0;
        w_tot = 0;
        wbeat = 0;
        pend_b = 0;
        fd_cnt = 0;
        in_w = 0;
        halted = 0;
    endtask

    task automatic model_pixel(input logic [7:0] d, input bit last);
        logic [255:0] beat;
        cur.push_back(d);
        if (cur.size() == 32 || last) begin
            beat = '0;
            foreach (cur[k]) beat = beat | (256'(cur[k]) << (8 * k));
            q.push_back(beat);
            cur.delete();
        end
    endtask

    task automatic idle_inputs();
        pxl_dat_i   = '0;
        pxl_vld_i   = 1'b0;
        pxl_last_i  = 1'b0;
        m_awready_i = 1'b0;
        m_wready_i  = 1'b0;
        m_bid_i     = '0;
        m_bresp_i   = 2'b00;
        m_bvalid_i  = 1'b0;
    endtask

    task automatic cfg(input int v, input int a, input int w, input int b,
                       input bit rd);
        vld_pct  = v;
        aw_pct   = a;
        w_pct    = w;
        b_pct    = b;
        rand_dat = rd;
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // One clock: drive at negedge, then predict the handshakes of the next posedge.
    task automatic step();
        logic [255:0] exp;
        bit bhs;
        @(negedge clk);
        if (rst_wbeat >= 0 && in_w && wbeat == rst_wbeat) begin
            rst = 1'b1;
            idle_inputs();
            rst_wbeat = -1;
            did_rst = 1;
            model_clear();
            return;
        end
        if (p < pix_total) begin
            pxl_vld_i  = roll(vld_pct);
            pxl_dat_i  = rand_dat ? 8'($urandom) : p[7:0];
            pxl_last_i = (p == last_at);
        end else begin
            pxl_vld_i  = 1'b0;
            pxl_dat_i  = '0;
            pxl_last_i = 1'b0;
        end
        m_awready_i = roll(aw_pct);
        m_wready_i  = roll(w_pct);
        m_bvalid_i  = (pend_b > 0) && roll(b_pct);
        m_bresp_i   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        m_bid_i     = 5'h01;
        #1;
        if (pxl_vld_i && pxl_rdy_o) begin
            model_pixel(pxl_dat_i, pxl_last_i);
            p++;
        end
        check("bready", m_bready_o, pend_b > 0);
        check("aw_excl", m_awvalid_o && (in_w || pend_b > 0), 0);
        if (halted) check("halt_aw", m_awvalid_o, 0);
        bhs = m_bready_o && m_bvalid_i;
        check("frame_done", frame_done_o, bhs && (b_cnt % NB == NB - 1));
        fd_cnt += int'(frame_done_o);
        if (bhs) begin
`ifdef DBI_DMA_BRESP_CHK_EN
            if (m_bresp_i != 2'b00) halted = 1;
`endif
            b_cnt++;
            pend_b--;
        end
        check(in_w ? "w_gap" : "w_idle", m_wvalid_o, in_w);
        if (m_wvalid_o && m_wready_i) begin
            check("w_q", q.size() > 0, 1);
            if (q.size() > 0) begin
                exp = q.pop_front();
                check("wdata", m_wdata_o, exp);
            end
            if (first_chk && w_tot == 0) check("first_wdata", m_wdata_o, first_beat);
            if (w_tot == pad_beat) check("pad_hi", m_wdata_o[255:64], 0);
            check("wlast", m_wlast_o, wbeat == BL - 1);
            w_tot++;
            wbeat++;
            if (wbeat == BL) begin
                wbeat = 0;
                in_w = 0;
                pend_b++;
            end
        end
        if (m_awvalid_o && m_awready_i) begin
            check("awaddr", m_awaddr_o, BASE + 32'((aw_cnt % NB) * 512));
            check("awlen", m_awlen_o, BL - 1);
            check("awid", m_awid_o, 5'h01);
            aw_cnt++;
            in_w = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_awvalid", m_awvalid_o, 0);
        check("rst_wvalid", m_wvalid_o, 0);
        check("rst_bready", m_bready_o, 0);
        check("rst_wlast", m_wlast_o, 0);
        check("rst_awaddr", m_awaddr_o, BASE);
        check("rst_awid", m_awid_o, 5'h01);
        check("rst_awlen", m_awlen_o, BL - 1);
        check("rst_wdata", m_wdata_o, 0);
        check("rst_fdone", frame_done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_pxl_rdy", pxl_rdy_o, 1);
        rst = 1'b0;
    endtask

    task automatic run(input int exp_b, input string tag);
        int cyc = 0;
        while ((p < pix_total || b_cnt < exp_b) && cyc < 20000) begin
            step();
            cyc++;
        end
        check({tag, "_pixels"}, p, pix_total);
        check({tag, "_bursts"}, b_cnt, exp_b);
        check({tag, "_q_empty"}, q.size(), 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        idle_inputs();
        for (int k = 0; k < 32; k++) first_beat[8*k +: 8] = 8'(k);
        pix_total = FRAME;
        last_at   = FRAME - 1;
        cfg(100, 100, 100, 100, 0);
        do_reset();

        // Ordered frame, no backpressure
        first_chk = 1;
        run(NB, "t1");
        first_chk = 0;
        check("t1_fd_cnt", fd_cnt, 1);
        check("t1_err", err_o, 0);
        do_reset();

        // Random data with random backpressure everywhere
        cfg(60, 50, 60, 40, 1);
        run(NB, "t2");
        check("t2_fd_cnt", fd_cnt, 1);
        do_reset();

        // AW stalled: FIFO fills to 32 beats
        cfg(100, 0, 100, 100, 1);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (pxl_rdy_o && cyc < 3000);
        check("t3_rdy_fall_pix", p, 1024);
        check("t3_rdy", pxl_rdy_o, 0);
        check("t3_awvalid", m_awvalid_o, 1);
        aw_pct = 100;
        run(NB, "t3");
        check("t3_fd_cnt", fd_cnt, 1);
        do_reset();

        // Early last on the 40th pixel, then 14 more full beats
        cfg(100, 100, 100, 100, 1);
        pix_total = 40 + 14 * 32;
        last_at   = 39;
        pad_beat  = 1;
        run(1, "t4");
        check("t4_err", err_o, 1);
        pad_beat  = -1;
        pix_total = FRAME;
        last_at   = FRAME - 1;
        do_reset();

        // SLVERR on the third burst
        cfg(70, 60, 70, 50, 1);
        err_burst = 2;
`ifdef DBI_DMA_BRESP_CHK_EN
        cyc = 0;
        while (b_cnt < 3 && cyc < 20000) begin
            step();
            cyc++;
        end
        repeat (300) step();
        check("t5_bursts", b_cnt, 3);
        check("t5_aw_cnt", aw_cnt, 3);
        check("t5_err", err_o, 1);
`else
        run(NB, "t5");
        check("t5_fd_cnt", fd_cnt, 1);
        check("t5_err", err_o, 0);
`endif
        err_burst = -1;
        do_reset();

        // Reset during W beat 7, then a clean frame
        cfg(100, 100, 100, 100, 0);
        rst_wbeat = 7;
        did_rst = 0;
        cyc = 0;
        while (!did_rst && cyc < 2000) begin
            step();
            cyc++;
        end
        check("t6_rst_hit", did_rst, 1);
        @(negedge clk);
        check("t6_awvalid", m_awvalid_o, 0);
        check("t6_wvalid", m_wvalid_o, 0);
        check("t6_bready", m_bready_o, 0);
        check("t6_awaddr", m_awaddr_o, BASE);
        check("t6_pxl_rdy", pxl_rdy_o, 1);
        rst = 1'b0;
        rst_wbeat = -1;
        run(NB, "t6");
        check("t6_fd_cnt", fd_cnt, 1);
        check("t6_err", err_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
